program_counter: RTL and testbench
==================================

# program_counter

Architectural program-counter register for the single-cycle/pipelined CPU datapath. It captures the next-PC value computed upstream (PC+4, branch or jump target mux) on each rising clock edge and presents it as the current fetch address to instruction memory. It also provides the sequential successor address. An optional alignment checker can be compiled in.

## Interface
Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded on reset.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- PC  input  WIDTH  next-PC value from the next-PC mux.
- PC_Write  input  1  load enable; low stalls the PC (holds its value).
- PC_Out  output  WIDTH  current PC (fetch address), registered.
- PC_Plus4  output  WIDTH  PC_Out + 4, combinational.
- misaligned  output  1  registered alignment fault flag; present only when PC_ALIGN_CHECK_EN is defined.

Clock and reset are fixed as one clock, `clock`, and a synchronous active-high `reset`.

## Operation
- On a rising edge with reset=1: PC_Out <= RESET_VECTOR and misaligned <= 0, regardless of PC_Write or PC.
- On a rising edge with reset=0 and PC_Write=1: PC_Out <= PC.
- On a rising edge with reset=0 and PC_Write=0: PC_Out holds. misaligned holds.
- PC_Plus4 = PC_Out + 4, computed modulo 2^WIDTH. 32'hFFFF_FFFC gives 32'h0000_0000; no carry out and no flag.
- PC_Out is driven by a flop only; there is no combinational path from PC to PC_Out.
- Reset has priority over every other input. Reset during a stall still loads RESET_VECTOR.
- X or Z on PC while PC_Write=0 must not disturb PC_Out.

## Timing
- Load latency is 1 cycle: PC sampled at edge N appears on PC_Out after edge N.
- PC_Plus4 follows PC_Out combinationally within the same cycle. It is registered-source, so its timing path is adder-only.
- Reset value of PC_Out is RESET_VECTOR, visible after the first edge with reset=1. Reset value of misaligned is 0.
- PC_Out is undefined before the first reset edge. The bench must apply reset before checking.
- misaligned updates on the same edge as the PC_Out load it describes.

## Configuration
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - On a load edge (reset=0, PC_Write=1), misaligned <= (PC[1:0] != 2'b00).
  - PC_Out <= {PC[WIDTH-1:2], 2'b00}, so the low two bits are forced to zero.
  - The `misaligned` port exists.
- When undefined:
  - PC is loaded verbatim.
  - The `misaligned` port and its logic are absent.

## Structure
- Shared package `pc_pkg`:
  - PC_WIDTH = 32.
  - PC_RESET_VECTOR = 32'h0000_0000.
  - INSTR_BYTES = 4.
  - typedef `pc_t` as logic [PC_WIDTH-1:0].
- One natural sub-module, `pc_align_check`: takes the candidate PC and returns the aligned address plus the fault bit. It is instantiated only under PC_ALIGN_CHECK_EN.
- The top-level holds the register, the enable/reset priority logic and the +4 adder.

## Test plan
- Reset: reset=1, PC=32'h0000_1234, PC_Write=1, one edge -> PC_Out=32'h0000_0000, PC_Plus4=32'h0000_0004.
- Load: reset=0, PC_Write=1, PC=32'h0040_0010, one edge -> PC_Out=32'h0040_0010 after that edge, not before; PC_Plus4=32'h0040_0014.
- Stall: PC_Out=32'h0000_0020, PC_Write=0, PC=32'h0000_0100, three edges -> PC_Out stays 32'h0000_0020.
- Reset during stall: PC_Write=0, reset=1, one edge -> PC_Out=RESET_VECTOR.
- Wrap: load 32'hFFFF_FFFC -> PC_Plus4=32'h0000_0000.
- Alignment with PC_ALIGN_CHECK_EN defined: load 32'h0000_0006 -> PC_Out=32'h0000_0004, misaligned=1. Next load 32'h0000_0008 -> misaligned=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared program-counter types and constants.
package pc_pkg;
  localparam int                  PC_WIDTH        = 32;
  localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam int                  INSTR_BYTES     = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;
endpackage

// File: rtl/pc_align_check.sv
// Word-alignment checker: clears the byte-offset bits and flags a nonzero offset.
module pc_align_check #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] aligned_pc,
  output logic             fault
);
  assign aligned_pc = {pc[WIDTH-1:2], 2'b00};
  assign fault      = |pc[1:0];
endmodule

// File: rtl/program_counter.sv
// Architectural PC register with stall enable and sequential successor output.
// Optional word-alignment check is compiled in with PC_ALIGN_CHECK_EN.
module program_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] PC,
  input  logic             PC_Write,
  output logic [WIDTH-1:0] PC_Out,
  output logic [WIDTH-1:0] PC_Plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misaligned
`endif
);
  logic [WIDTH-1:0] pc_d;

`ifdef PC_ALIGN_CHECK_EN
  logic fault_d;

  pc_align_check #(.WIDTH(WIDTH)) u_align (
    .pc         (PC),
    .aligned_pc (pc_d),
    .fault      (fault_d)
  );

  // Fault flag tracks the load it describes, so it shares the PC enable.
  always_ff @(posedge clock) begin
    if (reset)         misaligned <= 1'b0;
    else if (PC_Write) misaligned <= fault_d;
  end
`else
  assign pc_d = PC;
`endif

  always_ff @(posedge clock) begin
    if (reset)         PC_Out <= RESET_VECTOR;
    else if (PC_Write) PC_Out <= pc_d;
  end

  assign PC_Plus4 = PC_Out + WIDTH'(INSTR_BYTES);
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed cases then random traffic vs a reference model.
module tb_program_counter;
  import pc_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        PC_Write;
  logic [31:0] PC_Out;
  logic [31:0] PC_Plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int total = 0;
  int bad   = 0;

  pc_t exp_pc;
  logic exp_mis;

  always #5 clock = ~clock;

  program_counter dut (
    .clock    (clock),
    .reset    (reset),
    .PC       (PC),
    .PC_Write (PC_Write),
    .PC_Out   (PC_Out),
    .PC_Plus4 (PC_Plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned (misaligned)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: apply the architectural rules for one rising edge.
  task automatic model_edge();
    if (reset) begin
      exp_pc  = 32'h0000_0000;
      exp_mis = 1'b0;
    end else if (PC_Write) begin
`ifdef PC_ALIGN_CHECK_EN
      exp_pc  = PC - (PC % 4);
      exp_mis = (PC % 4) != 0;
`else
      exp_pc  = PC;
`endif
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc_out"}, PC_Out, exp_pc);
    chk({tag, ".pc_plus4"}, PC_Plus4, 32'((64'(exp_pc) + 64'd4) % 64'h1_0000_0000));
`ifdef PC_ALIGN_CHECK_EN
    chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, exp_mis});
`endif
  endtask

  initial begin
    exp_pc  = '0;
    exp_mis = 1'b0;

    // Reset overrides an active load
    reset = 1'b1; PC = 32'h0000_1234; PC_Write = 1'b1;
    #2;
    step();
    chk("reset.pc_out", PC_Out, 32'h0000_0000);
    chk("reset.pc_plus4", PC_Plus4, 32'h0000_0004);
    chk_all("reset");

    // Load: visible only after the edge
    reset = 1'b0; PC = 32'h0040_0010; PC_Write = 1'b1;
    #1;
    chk("load.before_edge", PC_Out, 32'h0000_0000);
    step();
    chk("load.pc_out", PC_Out, 32'h0040_0010);
    chk("load.pc_plus4", PC_Plus4, 32'h0040_0014);

    // Stall for three edges
    PC = 32'h0000_0020; step();
    chk("stall_setup", PC_Out, 32'h0000_0020);
    PC_Write = 1'b0; PC = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.pc_out", PC_Out, 32'h0000_0020);
    end

    // Unknown PC while stalled must not leak through
    PC = 'x; step();
    chk("stall_x.pc_out", PC_Out, 32'h0000_0020);
    chk("stall_x.pc_plus4", PC_Plus4, 32'h0000_0024);

    // Reset during stall
    PC = 32'h0000_0100; reset = 1'b1; step();
    chk("reset_stall.pc_out", PC_Out, 32'h0000_0000);
    reset = 1'b0;

    // Wrap of the successor address
    PC_Write = 1'b1; PC = 32'hFFFF_FFFC; step();
    chk("wrap.pc_out", PC_Out, 32'hFFFF_FFFC);
    chk("wrap.pc_plus4", PC_Plus4, 32'h0000_0000);

`ifdef PC_ALIGN_CHECK_EN
    PC = 32'h0000_0006; step();
    chk("align.pc_out", PC_Out, 32'h0000_0004);
    chk("align.mis_set", {31'd0, misaligned}, 32'd1);
    PC_Write = 1'b0; PC = 32'h0000_0003; step();
    chk("align.mis_hold", {31'd0, misaligned}, 32'd1);
    PC_Write = 1'b1; PC = 32'h0000_0008; step();
    chk("align.pc_out2", PC_Out, 32'h0000_0008);
    chk("align.mis_clr", {31'd0, misaligned}, 32'd0);
`endif

    // Random traffic: mixed loads, stalls and occasional resets
    for (int i = 0; i < 300; i++) begin
      PC       = $urandom;
      PC_Write = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 31) == 0);
      step();
      chk_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
